// File: rtl/stim_gen_pkg.sv
// Shared types and constants for the triple stimulus generator.
package stim_gen_pkg;

  localparam int TX_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/stim_gen_seq.sv
// x accumulator for the stimulus generator: loads seed, adds the latched step on
// each advance, and keeps y = x + 1 and z = ~x registered alongside x.
module stim_gen_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] x_next;

  always_comb begin
    x_next = x + step_q;
  end

  // y and z are registered too so that reset can force all three lanes to zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      z      <= '0;
      step_q <= '0;
    end else if (load) begin
      x      <= seed;
      y      <= seed + WIDTH'(1);
      z      <= ~seed;
      step_q <= step;
    end else if (advance) begin
      x <= x_next;
      y <= x_next + WIDTH'(1);
      z <= ~x_next;
    end
  end

endmodule

// File: rtl/triple_stim_gen.sv
// Triple-lane stimulus generator: emits COUNT (x, y, z) beats over a valid/ready handshake.
// Define STIM_GEN_DISPLAY_EN to print each transfer and the end-of-run count.
//
// state  | meaning
// IDLE   | waiting for start; tx_count holds the last run's total
// SEND   | presenting beats, one per accepted transfer
// FINISH | one-cycle done pulse, then back to IDLE
module triple_stim_gen
  import stim_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  input  logic [WIDTH-1:0]      step,
  output logic [WIDTH-1:0]      x,
  output logic [WIDTH-1:0]      y,
  output logic [WIDTH-1:0]      z,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [TX_COUNT_W-1:0] tx_count
);

  localparam logic [TX_COUNT_W-1:0] LAST_REMAIN =
    (COUNT > 0) ? TX_COUNT_W'(COUNT - 1) : '0;

  state_t                state;
  logic [TX_COUNT_W-1:0] remain;
  logic                  accept;
  logic                  xfer;
  logic                  last;
  logic                  advance;

  always_comb begin
    accept  = (state == IDLE) && start;
    xfer    = (state == SEND) && valid && ready;
    last    = (remain == '0);
    advance = xfer && !last;
  end

  stim_gen_seq #(
    .WIDTH(WIDTH)
  ) u_seq (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .advance (advance),
    .seed    (seed),
    .step    (step),
    .x       (x),
    .y       (y),
    .z       (z)
  );

  // remain counts down the beats still to go; terminal count marks the final beat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_count <= '0;
      remain   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            tx_count <= '0;
            busy     <= 1'b1;
            remain   <= LAST_REMAIN;
            if (COUNT > 0) begin
              state <= SEND;
              valid <= 1'b1;
            end else begin
              state <= FINISH;
              done  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (xfer) begin
            tx_count <= tx_count + 1'b1;
            if (last) begin
              valid <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              remain <= remain - 1'b1;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef STIM_GEN_DISPLAY_EN
  always @(posedge clock) begin
    if (!reset) begin
      if (xfer)
        $display("x=%0d, y=%0d, z=%0d", x, y, z);
      if (state == FINISH)
        $display("done n=%0d", tx_count);
    end
  end
`endif

endmodule

// File: tb/tb_triple_stim_gen.sv
// Bench for triple_stim_gen: four instances (COUNT = 4, 3, 0, 8) checked beat by beat
// against an arithmetic model of the x/y/z sequence and the run timing.
module tb_triple_stim_gen;

  localparam int W  = 8;
  localparam int NI = 4;

  function automatic int cnt_of(input int g);
    case (g)
      0:       return 4;
      1:       return 3;
      2:       return 0;
      default: return 8;
    endcase
  endfunction

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         start [NI];
  logic [W-1:0] seed  [NI];
  logic [W-1:0] step  [NI];
  logic [W-1:0] x     [NI];
  logic [W-1:0] y     [NI];
  logic [W-1:0] z     [NI];
  logic         valid [NI];
  logic         ready [NI];
  logic         busy  [NI];
  logic         done  [NI];
  logic [15:0]  txc   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    triple_stim_gen #(
      .WIDTH(W),
      .COUNT(cnt_of(g))
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start[g]),
      .seed     (seed[g]),
      .step     (step[g]),
      .x        (x[g]),
      .y        (y[g]),
      .z        (z[g]),
      .valid    (valid[g]),
      .ready    (ready[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .tx_count (txc[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: beat n of a run is seed + n*step reduced modulo 2^W
  function automatic int model_x(input int sd, input int st, input int n);
    return (sd + n * st) % (1 << W);
  endfunction

  task automatic check_idle_zero(input int i, input string tag);
    chk({tag, "_x"}, 32'(x[i]), 0);
    chk({tag, "_y"}, 32'(y[i]), 0);
    chk({tag, "_z"}, 32'(z[i]), 0);
    chk({tag, "_valid"}, 32'(valid[i]), 0);
    chk({tag, "_busy"}, 32'(busy[i]), 0);
    chk({tag, "_done"}, 32'(done[i]), 0);
    chk({tag, "_txc"}, 32'(txc[i]), 0);
  endtask

  typedef struct {
    int idx;   // instance: 0->COUNT4 1->COUNT3 2->COUNT0 3->COUNT8
    int sd;
    int st;
    int mode;  // 0 ready high, 1 stall 2 cycles on beat 1, 2 random ready
    bit poke;  // pulse start again during SEND
    int fx;    // expected first x (-1: no beat)
    int ftx;   // expected final tx_count
  } vec_t;

  // Starts a run on instance i and checks every cycle until it returns to IDLE
  task automatic run(input vec_t v);
    int i, c, n, stall, budget, xv;
    bit first;
    i = v.idx; c = cnt_of(i); n = 0; stall = 0; budget = 0; first = 1'b1;
    @(negedge clock);
    seed[i] = W'(v.sd); step[i] = W'(v.st); start[i] = 1'b1; ready[i] = 1'b1;
    @(negedge clock);
    start[i] = 1'b0;
    seed[i]  = W'($urandom);
    step[i]  = W'($urandom);
    while (n < c && budget < 200) begin
      case (v.mode)
        0:       ready[i] = 1'b1;
        1: begin
          ready[i] = !(n == 1 && stall < 2);
          if (n == 1) stall++;
        end
        default: ready[i] = 1'($urandom_range(0, 1));
      endcase
      if (v.poke && n == 1) begin
        start[i] = 1'b1;
        seed[i]  = W'(v.sd + 77);
      end else begin
        start[i] = 1'b0;
      end
      xv = model_x(v.sd, v.st, n);
      if (first && v.fx >= 0) chk("first_x", 32'(x[i]), 32'(v.fx));
      first = 1'b0;
      chk("beat_valid", 32'(valid[i]), 1);
      chk("beat_x", 32'(x[i]), 32'(xv));
      chk("beat_y", 32'(y[i]), 32'((xv + 1) % (1 << W)));
      chk("beat_z", 32'(z[i]), 32'((1 << W) - 1 - xv));
      chk("beat_busy", 32'(busy[i]), 1);
      chk("beat_done", 32'(done[i]), 0);
      chk("beat_txc", 32'(txc[i]), 32'(n));
      @(posedge clock);
      if (ready[i]) n++;
      @(negedge clock);
      budget++;
    end
    start[i] = 1'b0;
    if (budget >= 200) chk("run_timeout", 1, 0);
    ready[i] = (v.mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    chk("fin_valid", 32'(valid[i]), 0);
    chk("fin_done", 32'(done[i]), 1);
    chk("fin_busy", 32'(busy[i]), 1);
    chk("fin_txc", 32'(txc[i]), 32'(v.ftx));
    @(negedge clock);
    chk("idle_done", 32'(done[i]), 0);
    chk("idle_busy", 32'(busy[i]), 0);
    chk("idle_valid", 32'(valid[i]), 0);
    chk("idle_txc", 32'(txc[i]), 32'(v.ftx));
    @(negedge clock);
    chk("hold_txc", 32'(txc[i]), 32'(v.ftx));
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; seed[i] = '0; step[i] = '0; ready[i] = 1'b0;
    end
    vecs.push_back('{idx: 0, sd: 5,   st: 3, mode: 0, poke: 0, fx: 5,   ftx: 4});
    vecs.push_back('{idx: 1, sd: 0,   st: 1, mode: 1, poke: 0, fx: 0,   ftx: 3});
    vecs.push_back('{idx: 1, sd: 250, st: 4, mode: 0, poke: 0, fx: 250, ftx: 3});
    vecs.push_back('{idx: 2, sd: 7,   st: 1, mode: 0, poke: 0, fx: -1,  ftx: 0});
    vecs.push_back('{idx: 0, sd: 5,   st: 3, mode: 0, poke: 1, fx: 5,   ftx: 4});
    for (int k = 0; k < 6; k++) begin
      int rs, rt;
      rs = int'($urandom_range(0, 255));
      rt = int'($urandom_range(0, 255));
      vecs.push_back('{idx: 3, sd: rs, st: rt, mode: 2, poke: k[0], fx: rs, ftx: 8});
    end

    // start held through reset and the release edge must not begin a run
    start[0] = 1'b1;
    @(negedge clock);
    for (int i = 0; i < NI; i++) check_idle_zero(i, "por");
    @(posedge clock);
    #1;
    reset    = 1'b0;
    start[0] = 1'b0;
    @(negedge clock);
    chk("release_busy", 32'(busy[0]), 0);
    chk("release_valid", 32'(valid[0]), 0);
    @(negedge clock);
    chk("release_busy2", 32'(busy[0]), 0);

    foreach (vecs[k]) run(vecs[k]);

    // reset in the middle of a COUNT=8 run
    @(negedge clock);
    seed[3] = 8'd20; step[3] = 8'd7; start[3] = 1'b1; ready[3] = 1'b1;
    @(negedge clock);
    start[3] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("mid_txc", 32'(txc[3]), 2);
    chk("mid_x", 32'(x[3]), 34);
    #2 reset = 1'b1;
    #1 check_idle_zero(3, "abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("abort_no_done", 32'(done[3]), 0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("after_abort_done", 32'(done[3]), 0);
    run('{idx: 3, sd: 9, st: 2, mode: 0, poke: 0, fx: 9, ftx: 8});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
